// File: rtl/rd_strobe_fifo_if.sv
// Handshake bundle between the result-producing core, the read-strobe host and
// rd_strobe_fifo. The master side is the core/host; the slave side is the FIFO.
interface rd_strobe_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  WR_EN;
  logic [WIDTH-1:0]      WR_DATA;
  logic                  FULL;
  logic                  RD;
  logic [WIDTH-1:0]      DOUT;
  logic                  DOUT_VALID;
  logic                  EMPTY;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  ERR_CLR;
  logic                  OVF;
  logic                  UNF;

  modport master (
    output WR_EN, WR_DATA, RD, ERR_CLR,
    input  FULL, DOUT, DOUT_VALID, EMPTY, COUNT, OVF, UNF
  );

  modport slave (
    input  WR_EN, WR_DATA, RD, ERR_CLR,
    output FULL, DOUT, DOUT_VALID, EMPTY, COUNT, OVF, UNF
  );
endinterface

// File: rtl/rd_strobe_fifo.sv
// Read-side output FIFO: the core pushes words and each rising edge of the level
// strobe RD pops one word into the registered DOUT. Overflow and underflow are sticky.
module rd_strobe_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic            CLK,
  input  logic            RST,
  rd_strobe_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = (DEPTH_LOG2)'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
  localparam logic [WIDTH-1:0]      DATA_ZERO = (WIDTH)'(0);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_r;
  logic [DEPTH_LOG2-1:0] rptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  rd_q_r;
  logic                  pop_req_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  ovf_evt_s;
  logic                  unf_evt_s;
  logic [WIDTH-1:0]      dout_r;
  logic                  dout_valid_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  ovf_r;
  logic                  unf_r;

  // Edge-detect the strobe and qualify push/pop against the current fill level.
  always_comb begin
    pop_req_s   = bus.RD & ~rd_q_r;
    pop_s       = pop_req_s & (count_r != CNT_ZERO);
    unf_evt_s   = pop_req_s & (count_r == CNT_ZERO);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    push_s      = bus.WR_EN & ((count_r != CNT_FULL) | pop_s);
    ovf_evt_s   = bus.WR_EN & ~push_s;
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push_s && !RST) begin
      mem_r[wptr_r] <= bus.WR_DATA;
    end
  end

  // Pointers, fill level, strobe history, output word and sticky error flags.
  always_ff @(posedge CLK) begin
    rd_q_r <= bus.RD;
    if (RST) begin
      wptr_r       <= PTR_ZERO;
      rptr_r       <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      dout_r       <= DATA_ZERO;
      dout_valid_r <= 1'b0;
      ovf_r        <= 1'b0;
      unf_r        <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CNT_ZERO);
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        dout_r <= mem_r[rptr_r];
        rptr_r <= rptr_r + PTR_ONE;
      end
      if (!bus.RD) begin
        dout_valid_r <= 1'b0;
      end else if (pop_s) begin
        dout_valid_r <= 1'b1;
      end
      // A new error event in the same cycle as ERR_CLR keeps the flag set.
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end else if (bus.ERR_CLR) begin
        ovf_r <= 1'b0;
      end
      if (unf_evt_s) begin
        unf_r <= 1'b1;
      end else if (bus.ERR_CLR) begin
        unf_r <= 1'b0;
      end
    end
  end

  assign bus.DOUT       = dout_r;
  assign bus.DOUT_VALID = dout_valid_r;
  assign bus.COUNT      = count_r;
  assign bus.FULL       = full_r;
  assign bus.EMPTY      = empty_r;
  assign bus.OVF        = ovf_r;
  assign bus.UNF        = unf_r;
endmodule

// File: tb/tb_rd_strobe_fifo.sv
// Directed self-checking bench for rd_strobe_fifo: strobe edge conversion, fill,
// overflow/underflow flags, simultaneous push/pop and strobe held across reset.
module tb_rd_strobe_fifo;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  rd_strobe_fifo_if #(.WIDTH(8), .DEPTH_LOG2(4)) bus_if ();

  rd_strobe_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus_if.WR_EN   = 1'b1;
    bus_if.WR_DATA = d;
    tick();
    bus_if.WR_EN   = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    bus_if.RD = 1'b1;
    tick();
    chk({tag, "_valid"}, 32'(bus_if.DOUT_VALID), 32'd1);
    chk({tag, "_dout"}, 32'(bus_if.DOUT), 32'(exp));
    bus_if.RD = 1'b0;
    tick();
  endtask

  initial begin
    RST            = 1'b1;
    bus_if.WR_EN   = 1'b0;
    bus_if.WR_DATA = 8'h00;
    bus_if.RD      = 1'b0;
    bus_if.ERR_CLR = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk("rst_count", 32'(bus_if.COUNT), 32'd0);
    chk("rst_empty", 32'(bus_if.EMPTY), 32'd1);
    chk("rst_full", 32'(bus_if.FULL), 32'd0);
    chk("rst_dout", 32'(bus_if.DOUT), 32'd0);
    chk("rst_valid", 32'(bus_if.DOUT_VALID), 32'd0);
    chk("rst_ovf", 32'(bus_if.OVF), 32'd0);
    chk("rst_unf", 32'(bus_if.UNF), 32'd0);

    // 1: long strobe pops exactly once
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("t1_count3", 32'(bus_if.COUNT), 32'd3);
    bus_if.RD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold_valid", 32'(bus_if.DOUT_VALID), 32'd1);
      chk("t1_hold_dout", 32'(bus_if.DOUT), 32'h11);
      chk("t1_hold_count", 32'(bus_if.COUNT), 32'd2);
    end
    bus_if.RD = 1'b0;
    tick();
    chk("t1_fall_valid", 32'(bus_if.DOUT_VALID), 32'd0);
    chk("t1_fall_dout", 32'(bus_if.DOUT), 32'h11);
    pop_chk("t1_pop22", 8'h22);
    pop_chk("t1_pop33", 8'h33);
    chk("t1_empty", 32'(bus_if.EMPTY), 32'd1);

    // 2: fill from pointer 3 so reads wrap, then overflow
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full", 32'(bus_if.FULL), 32'd1);
    chk("t2_count16", 32'(bus_if.COUNT), 32'd16);
    chk("t2_ovf_pre", 32'(bus_if.OVF), 32'd0);
    push(8'hAA);
    chk("t2_ovf", 32'(bus_if.OVF), 32'd1);
    chk("t2_count_drop", 32'(bus_if.COUNT), 32'd16);
    bus_if.ERR_CLR = 1'b1;
    tick();
    bus_if.ERR_CLR = 1'b0;
    chk("t2_ovf_clr", 32'(bus_if.OVF), 32'd0);

    // 4: push while full alongside a rising strobe
    bus_if.WR_EN   = 1'b1;
    bus_if.WR_DATA = 8'h5A;
    bus_if.RD      = 1'b1;
    tick();
    bus_if.WR_EN   = 1'b0;
    chk("t4_dout", 32'(bus_if.DOUT), 32'h00);
    chk("t4_count", 32'(bus_if.COUNT), 32'd16);
    chk("t4_full", 32'(bus_if.FULL), 32'd1);
    chk("t4_ovf", 32'(bus_if.OVF), 32'd0);
    bus_if.RD = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) pop_chk("t2_order", 8'(i));
    pop_chk("t4_last", 8'h5A);
    chk("t2_empty", 32'(bus_if.EMPTY), 32'd1);
    chk("t2_count0", 32'(bus_if.COUNT), 32'd0);

    // 3: underflow and clear priority
    bus_if.RD = 1'b1;
    tick();
    chk("t3_unf", 32'(bus_if.UNF), 32'd1);
    chk("t3_valid", 32'(bus_if.DOUT_VALID), 32'd0);
    chk("t3_dout", 32'(bus_if.DOUT), 32'h5A);
    chk("t3_count", 32'(bus_if.COUNT), 32'd0);
    bus_if.RD = 1'b0;
    tick();
    bus_if.ERR_CLR = 1'b1;
    tick();
    bus_if.ERR_CLR = 1'b0;
    chk("t3_unf_clr", 32'(bus_if.UNF), 32'd0);
    bus_if.ERR_CLR = 1'b1;
    bus_if.RD      = 1'b1;
    tick();
    bus_if.ERR_CLR = 1'b0;
    bus_if.RD      = 1'b0;
    chk("t3_unf_win", 32'(bus_if.UNF), 32'd1);
    tick();
    chk("t3_unf_sticky", 32'(bus_if.UNF), 32'd1);
    bus_if.ERR_CLR = 1'b1;
    tick();
    bus_if.ERR_CLR = 1'b0;

    // 5: write into empty with same-cycle strobe, no fall-through
    bus_if.WR_EN   = 1'b1;
    bus_if.WR_DATA = 8'h77;
    bus_if.RD      = 1'b1;
    tick();
    bus_if.WR_EN   = 1'b0;
    chk("t5_unf", 32'(bus_if.UNF), 32'd1);
    chk("t5_count", 32'(bus_if.COUNT), 32'd1);
    chk("t5_valid", 32'(bus_if.DOUT_VALID), 32'd0);
    chk("t5_dout", 32'(bus_if.DOUT), 32'h5A);
    bus_if.RD = 1'b0;
    tick();
    pop_chk("t5_pop", 8'h77);

    // 6: reset mid-strobe, strobe held across release
    push(8'h44);
    push(8'h45);
    bus_if.RD = 1'b1;
    tick();
    chk("t6_pre_dout", 32'(bus_if.DOUT), 32'h44);
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("t6_rst_count", 32'(bus_if.COUNT), 32'd0);
    chk("t6_rst_dout", 32'(bus_if.DOUT), 32'h00);
    chk("t6_rst_valid", 32'(bus_if.DOUT_VALID), 32'd0);
    chk("t6_rst_empty", 32'(bus_if.EMPTY), 32'd1);
    push(8'h99);
    push(8'h66);
    tick();
    chk("t6_held_count", 32'(bus_if.COUNT), 32'd2);
    chk("t6_held_valid", 32'(bus_if.DOUT_VALID), 32'd0);
    chk("t6_held_dout", 32'(bus_if.DOUT), 32'h00);
    bus_if.RD = 1'b0;
    tick();
    chk("t6_low_count", 32'(bus_if.COUNT), 32'd2);
    pop_chk("t6_pop", 8'h99);
    chk("t6_count1", 32'(bus_if.COUNT), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
